// File: rtl/led_matrix_scanner.sv
// Column-multiplexed PWM driver for the iceFUN 8x4 LED matrix.
// Images are snapshotted once per frame so the scan never shows a torn update.
module led_matrix_scanner #(
  parameter int COL_PERIOD_LOG2 = 12,
  parameter int PWM_WIDTH       = 4
) (
  input  logic                 clk12MHz,
  input  logic                 reset,
  input  logic [7:0]           leds1,
  input  logic [7:0]           leds2,
  input  logic [7:0]           leds3,
  input  logic [7:0]           leds4,
  input  logic [PWM_WIDTH-1:0] leds_pwm,
  output logic                 led1,
  output logic                 led2,
  output logic                 led3,
  output logic                 led4,
  output logic                 led5,
  output logic                 led6,
  output logic                 led7,
  output logic                 led8,
  output logic                 lcol1,
  output logic                 lcol2,
  output logic                 lcol3,
  output logic                 lcol4
);

  localparam int CW = COL_PERIOD_LOG2 + 2;

  logic [CW-1:0]        cnt;
  logic [1:0]           col;
  logic [PWM_WIDTH-1:0] slot;
  logic                 frame_end;
  logic                 lit;

  logic [3:0][7:0]      snap_img;
  logic [PWM_WIDTH-1:0] snap_pwm;

  logic [7:0]           row_d;
  logic [3:0]           col_d;
  logic [7:0]           row_q;
  logic [3:0]           col_q;

  assign col       = cnt[CW-1 -: 2];
  assign slot      = cnt[COL_PERIOD_LOG2-1 -: PWM_WIDTH];
  assign frame_end = (cnt == '1);
  // last slot can never satisfy slot < pwm: built-in anti-ghost gap
  assign lit       = (slot < snap_pwm);

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      snap_img <= '0;
      snap_pwm <= '0;
    end else if (frame_end) begin
      snap_img <= {leds4, leds3, leds2, leds1};
      snap_pwm <= leds_pwm;
    end
  end

  always_comb begin
    row_d = 8'hFF;
    col_d = 4'hF;
    if (lit) begin
      row_d = ~snap_img[col];
      for (int i = 0; i < 4; i++) begin
        col_d[i] = (col != 2'(i));
      end
    end
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      row_q <= 8'hFF;
      col_q <= 4'hF;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign led1  = row_q[0];
  assign led2  = row_q[1];
  assign led3  = row_q[2];
  assign led4  = row_q[3];
  assign led5  = row_q[4];
  assign led6  = row_q[5];
  assign led7  = row_q[6];
  assign led8  = row_q[7];
  assign lcol1 = col_q[0];
  assign lcol2 = col_q[1];
  assign lcol3 = col_q[2];
  assign lcol4 = col_q[3];

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: scoreboarded small-period scan
// plus a default-parameter lit-time measurement.
module tb_led_matrix_scanner;

  localparam int CPL = 6;
  localparam int PW  = 4;
  localparam int CP  = 1 << CPL;
  localparam int FR  = 4 * CP;
  localparam int DFR = 4 * 4096;

  logic          clk12MHz = 1'b0;
  logic          reset;
  logic [7:0]    leds1, leds2, leds3, leds4;
  logic [PW-1:0] leds_pwm;
  logic led1, led2, led3, led4, led5, led6, led7, led8;
  logic lcol1, lcol2, lcol3, lcol4;
  logic [7:0] d_led;
  logic [3:0] d_col;

  always #5 clk12MHz = ~clk12MHz;

  led_matrix_scanner #(.COL_PERIOD_LOG2(CPL), .PWM_WIDTH(PW)) dut (
    .clk12MHz(clk12MHz), .reset(reset),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
    .leds_pwm(leds_pwm),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4),
    .led5(led5), .led6(led6), .led7(led7), .led8(led8),
    .lcol1(lcol1), .lcol2(lcol2), .lcol3(lcol3), .lcol4(lcol4)
  );

  led_matrix_scanner dut_d (
    .clk12MHz(clk12MHz), .reset(reset),
    .leds1(leds1), .leds2(leds2), .leds3(leds3), .leds4(leds4),
    .leds_pwm(leds_pwm),
    .led1(d_led[0]), .led2(d_led[1]), .led3(d_led[2]), .led4(d_led[3]),
    .led5(d_led[4]), .led6(d_led[5]), .led7(d_led[6]), .led8(d_led[7]),
    .lcol1(d_col[0]), .lcol2(d_col[1]), .lcol3(d_col[2]), .lcol4(d_col[3])
  );

  int total = 0;
  int bad   = 0;

  int          m_cnt;
  logic [7:0]  m_img [4];
  logic [PW-1:0] m_pwm;
  logic [11:0] sb [$];

  int          low_cnt [4];
  logic [7:0]  fled [4];
  logic        fgot [4];
  int          prev_idx;
  int          last_col;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pins();
    return {lcol4, lcol3, lcol2, lcol1,
            led8, led7, led6, led5, led4, led3, led2, led1};
  endfunction

  function automatic logic [11:0] model_out();
    int c = m_cnt / CP;
    int ph = m_cnt % CP;
    int s = ph / (CP >> PW);
    if (s >= int'(m_pwm)) return 12'hFFF;
    return {~(4'b0001 << c), ~m_img[c]};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_pwm = '0;
    for (int i = 0; i < 4; i++) m_img[i] = 8'h00;
    sb.delete();
    prev_idx = -1;
    last_col = -1;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) begin
      low_cnt[i] = 0;
      fgot[i] = 1'b0;
      fled[i] = 8'hxx;
    end
  endtask

  task automatic step();
    logic [11:0] e, g;
    int idx;
    sb.push_back(model_out());
    if (m_cnt == FR - 1) begin
      m_img[0] = leds1; m_img[1] = leds2;
      m_img[2] = leds3; m_img[3] = leds4;
      m_pwm = leds_pwm;
    end
    m_cnt = (m_cnt + 1) % FR;
    @(posedge clk12MHz);
    #1;
    e = sb.pop_front();
    g = pins();
    chk("scan", 32'(g), 32'(e));
    chk("excl", 32'($countones(~g[11:8]) <= 1), 32'd1);
    idx = -1;
    for (int i = 0; i < 4; i++) if (!g[8+i]) idx = i;
    if (idx >= 0) begin
      low_cnt[idx]++;
      if (!fgot[idx]) begin
        fgot[idx] = 1'b1;
        fled[idx] = g[7:0];
      end
      if (idx != prev_idx) begin
        chk("gap", 32'(prev_idx), -32'sd1);
        if (last_col >= 0) chk("order", 32'(idx), 32'((last_col + 1) % 4));
        last_col = idx;
      end
    end
    prev_idx = idx;
  endtask

  task automatic chk_counts(input string tag, input int n);
    for (int i = 0; i < 4; i++) chk(tag, 32'(low_cnt[i]), 32'(n));
  endtask

  int d_low1, d_low2, d_first1, d_last1, d_dark;

  initial begin
    reset = 1'b1;
    leds1 = 8'h00; leds2 = 8'h00; leds3 = 8'h00; leds4 = 8'h00;
    leds_pwm = '0;
    model_reset();
    repeat (3) @(posedge clk12MHz);
    #1;
    chk("rst_pins", 32'(pins()), 32'hFFF);
    chk("rst_cnt", 32'(dut.cnt), 32'd0);

    // frame 1: snapshot still zero, must stay dark
    reset = 1'b0;
    leds1 = 8'h01; leds2 = 8'h80; leds3 = 8'hFF; leds4 = 8'h00;
    leds_pwm = 4'd15;
    clr();
    repeat (FR) step();
    chk_counts("f1_dark", 0);

    // frame 2: basic pattern at full brightness
    leds_pwm = 4'd0;
    clr();
    repeat (FR) step();
    chk_counts("f2_lit60", 60);
    chk("f2_col1", 32'(fled[0]), 32'hFE);
    chk("f2_col2", 32'(fled[1]), 32'h7F);
    chk("f2_col3", 32'(fled[2]), 32'h00);
    chk("f2_col4", 32'(fled[3]), 32'hFF);

    // frame 3: pwm 0
    leds_pwm = 4'd8;
    clr();
    repeat (FR) step();
    chk_counts("pwm0", 0);

    // frame 4: pwm 8
    leds1 = 8'h0F;
    leds_pwm = 4'd15;
    clr();
    repeat (FR) step();
    chk_counts("pwm8", 32);

    // frame 5: leds1 changes while column 3 is scanned
    clr();
    repeat (2 * CP + 20) step();
    leds1 = 8'hF0;
    repeat (FR - (2 * CP + 20)) step();
    chk("tear_f5", 32'(fled[0]), 32'hF0);
    chk_counts("f5_lit60", 60);

    // frame 6: new image visible
    clr();
    repeat (FR) step();
    chk("tear_f6", 32'(fled[0]), 32'h0F);

    // frame 7: async reset while column 2 is lit
    clr();
    repeat (CP + 16) step();
    chk("prelit", 32'(pins() & 12'hF00), 32'hD00);
    #2;
    reset = 1'b1;
    #1;
    chk("amid_pins", 32'(pins()), 32'hFFF);
    chk("amid_cnt", 32'(dut.cnt), 32'd0);
    model_reset();
    @(posedge clk12MHz);
    #1;
    chk("hold_pins", 32'(pins()), 32'hFFF);
    reset = 1'b0;

    clr();
    repeat (FR) step();
    chk_counts("post_dark", 0);
    clr();
    repeat (4) step();
    chk("restart_col1", 32'(pins()), 32'hE0F);
    repeat (FR - 4) step();
    chk_counts("post_lit60", 60);

    // default parameters: 4096-cycle columns, 3840 lit
    reset = 1'b1;
    #2;
    chk("d_rst", 32'({d_col, d_led}), 32'hFFF);
    @(posedge clk12MHz);
    #1;
    reset = 1'b0;
    leds_pwm = 4'd15;
    d_low1 = 0; d_low2 = 0; d_dark = 0;
    d_first1 = -1; d_last1 = -1;
    for (int i = 0; i < 2 * DFR; i++) begin
      @(posedge clk12MHz);
      #1;
      if (i < DFR) begin
        if (d_col != 4'hF) d_dark++;
      end else begin
        if (!d_col[0]) begin
          d_low1++;
          if (d_first1 < 0) d_first1 = i;
          d_last1 = i;
        end
        if (!d_col[1]) d_low2++;
      end
    end
    chk("d_f1_dark", 32'(d_dark), 32'd0);
    chk("d_lit1", 32'(d_low1), 32'd3840);
    chk("d_lit2", 32'(d_low2), 32'd3840);
    chk("d_first1", 32'(d_first1), 32'(DFR));
    chk("d_last1", 32'(d_last1), 32'(DFR + 3839));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
